// File: rtl/data_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Loads hit in the on-chip arrays with zero wait; read misses fetch a 64-bit
// line from the SRAM controller; every store is written through to SRAM.
// `ready` low freezes the pipeline while an SRAM transaction is outstanding.
module data_cache_controller #(
    parameter int unsigned BASE_ADDR = 32'd1024,
    parameter int unsigned SETS      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } state_t;

    // Select one 32-bit word of a 64-bit line.
    function automatic logic [31:0] pick_word(input logic [63:0] line, input logic sel);
        logic [31:0] w;
        if (sel) begin
            w = line[63:32];
        end else begin
            w = line[31:0];
        end
        return w;
    endfunction

    // Replace one 32-bit word of a 64-bit line.
    function automatic logic [63:0] merge_word(input logic [63:0] line, input logic sel,
                                               input logic [31:0] word);
        logic [63:0] l;
        if (sel) begin
            l = {word, line[31:0]};
        end else begin
            l = {line[63:32], word};
        end
        return l;
    endfunction

    // Cache state
    state_t              state_r;
    state_t              state_next_s;
    logic [SETS-1:0]     valid0_r;
    logic [SETS-1:0]     valid1_r;
    logic [SETS-1:0]     lru_r;
    logic [TAG_W-1:0]    tag0_r  [SETS];
    logic [TAG_W-1:0]    tag1_r  [SETS];
    logic [63:0]         data0_r [SETS];
    logic [63:0]         data1_r [SETS];

    // Address decode
    logic [31:0]         a_s;
    logic                word_sel_s;
    logic [IDX_W-1:0]    set_s;
    logic [TAG_W-1:0]    tag_s;
    logic                unused_addr_bits_s;

    // Lookup results and update strobes
    logic                hit0_s;
    logic                hit1_s;
    logic                hit_s;
    logic                hit_way_s;
    logic [63:0]         hit_line_s;
    logic                victim_s;
    logic                fill_s;
    logic                wr_hit_s;
    logic                rd_hit_s;

    assign a_s                = addr - BASE_ADDR;
    assign word_sel_s         = a_s[2];
    assign set_s              = a_s[IDX_W+2:3];
    assign tag_s              = a_s[18:9];
    assign unused_addr_bits_s = ^{a_s[31:19], a_s[1:0]};

    assign sram_addr  = addr;
    assign sram_wdata = wdata;

    assign hit0_s    = valid0_r[set_s] && (tag0_r[set_s] == tag_s);
    assign hit1_s    = valid1_r[set_s] && (tag1_r[set_s] == tag_s);
    assign hit_s     = hit0_s || hit1_s;
    assign hit_way_s = hit1_s;

    // Pick the line of the hitting way and the replacement victim for this set.
    always_comb begin
        hit_line_s = 64'd0;
        victim_s   = 1'b0;
        if (hit1_s) begin
            hit_line_s = data1_r[set_s];
        end else begin
            hit_line_s = data0_r[set_s];
        end
        if (!valid0_r[set_s]) begin
            victim_s = 1'b0;
        end else if (!valid1_r[set_s]) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[set_s];
        end
    end

    // Next-state, handshake outputs and array update strobes.
    always_comb begin
        state_next_s = state_r;
        ready        = 1'b1;
        sram_r_en    = 1'b0;
        sram_w_en    = 1'b0;
        rdata        = 32'd0;
        fill_s       = 1'b0;
        wr_hit_s     = 1'b0;
        rd_hit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_w_en) begin
                    // Stores win over loads when both are asserted.
                    sram_w_en    = 1'b1;
                    ready        = 1'b0;
                    wr_hit_s     = hit_s;
                    state_next_s = WR_THRU;
                end else if (mem_r_en) begin
                    if (hit_s) begin
                        rdata    = pick_word(hit_line_s, word_sel_s);
                        rd_hit_s = 1'b1;
                    end else begin
                        sram_r_en    = 1'b1;
                        ready        = 1'b0;
                        state_next_s = RD_MISS;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_MISS: begin
                sram_r_en = 1'b1;
                if (sram_ready) begin
                    rdata        = pick_word(sram_rdata, word_sel_s);
                    fill_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    ready = 1'b0;
                end
            end
            WR_THRU: begin
                sram_w_en = 1'b1;
                if (sram_ready) begin
                    state_next_s = IDLE;
                end else begin
                    ready = 1'b0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // While reset is held, outputs show their idle values and nothing is written.
        if (!rst) begin
            state_next_s = IDLE;
            ready        = 1'b1;
            sram_r_en    = 1'b0;
            sram_w_en    = 1'b0;
            rdata        = 32'd0;
            fill_s       = 1'b0;
            wr_hit_s     = 1'b0;
            rd_hit_s     = 1'b0;
        end else begin
            fill_s = fill_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Valid bits and LRU pointers; cleared by reset, updated on fills and hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0_r <= '0;
            valid1_r <= '0;
            lru_r    <= '0;
        end else if (fill_s) begin
            if (victim_s) begin
                valid1_r[set_s] <= 1'b1;
            end else begin
                valid0_r[set_s] <= 1'b1;
            end
            lru_r[set_s] <= ~victim_s;
        end else if (wr_hit_s || rd_hit_s) begin
            lru_r[set_s] <= ~hit_way_s;
        end
    end

    // Tag and data arrays; contents are only meaningful under a valid bit.
    always_ff @(posedge clk) begin
        if (fill_s) begin
            if (victim_s) begin
                tag1_r[set_s]  <= tag_s;
                data1_r[set_s] <= sram_rdata;
            end else begin
                tag0_r[set_s]  <= tag_s;
                data0_r[set_s] <= sram_rdata;
            end
        end else if (wr_hit_s) begin
            if (hit_way_s) begin
                data1_r[set_s] <= merge_word(data1_r[set_s], word_sel_s, wdata);
            end else begin
                data0_r[set_s] <= merge_word(data0_r[set_s], word_sel_s, wdata);
            end
        end
    end

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Two-way set-associative, write-through, no-write-allocate data cache placed between the MEM stage and the SRAM controller. Serves MEM-stage loads from on-chip tag/data arrays. Sequences the SRAM controller only on read misses (64-bit line fill) and on every store (32-bit write-through). Drives `ready` to freeze the pipeline while an SRAM transaction is outstanding.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0; subtracted before indexing.
- `SETS`, 64: number of sets. Index width is log2(SETS) = 6. Tag is bits [18:9].
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_r_en` in 1: load request from the MEM stage.
- `mem_w_en` in 1: store request from the MEM stage.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data.
- `rdata` out 32: load data; valid when `ready`=1 and `mem_r_en`=1.
- `ready` out 1: request complete or no request; 0 freezes the pipeline.
- `sram_r_en` out 1: read request to the SRAM controller.
- `sram_w_en` out 1: write request to the SRAM controller.
- `sram_addr` out 32: `addr`, passed through unmodified.
- `sram_wdata` out 32: `wdata`, passed through.
- `sram_rdata` in 64: line returned by the SRAM controller.
- `sram_ready` in 1: SRAM controller transaction done.

## Operation
- Address decode, with a = addr − BASE_ADDR (32-bit, wraps modulo 2^32):
  - word select = a[2]
  - set = a[8:3]
  - tag = a[18:9]
  - a[1:0] ignored.
- Per way per set: valid (1 bit), tag (10 bits), data (64 bits). Per set: lru (1 bit) = index of the least-recently-used way.
- Hit = valid && tag match in either way. Both ways hitting cannot occur.
- States:
  - IDLE: accepts requests.
  - RD_MISS: waiting for the line fill.
  - WR_THRU: waiting for the SRAM write.
- If `mem_w_en` and `mem_r_en` are both 1, the request is handled as a store.
- IDLE, no request: `ready`=1, both SRAM enables 0.
- IDLE, read hit:
  - `rdata` = selected word of the hit way, combinationally.
  - `ready`=1 the same cycle.
  - lru[set] ← ~hit_way. No SRAM access.
- IDLE, read miss:
  - `sram_r_en`=1 and `ready`=0 combinationally.
  - Next state RD_MISS.
- RD_MISS:
  - `sram_r_en`=1 and `ready`=0 until `sram_ready`=1.
  - In the cycle `sram_ready`=1: `rdata` = `sram_rdata` word (a[2]=0 → [31:0], a[2]=1 → [63:32]), `ready`=1, `sram_r_en` still 1.
  - Victim: way0 if invalid, else way1 if invalid, else lru[set].
  - At that edge: victim ← {valid=1, tag, sram_rdata}, lru[set] ← ~victim, next state IDLE.
- IDLE, store:
  - `sram_w_en`=1 and `ready`=0. Next state WR_THRU.
  - If hit: the selected 32-bit word of the hit way ← `wdata` at this edge, and lru[set] ← ~hit_way.
  - If miss: the cache is unchanged.
- WR_THRU:
  - `sram_w_en`=1 until `sram_ready`=1.
  - In that cycle `ready`=1, then next state IDLE.
- The requester holds `addr`, `wdata` and the enables stable while `ready`=0.
- `sram_addr`/`sram_wdata` are pure pass-through. The SRAM enables are decoded from the state plus the IDLE hit/miss decode.

## Timing
- Reset (`rst`=0, asynchronous):
  - state ← IDLE; all valid bits and lru ← 0.
  - Outputs during reset: `ready`=1, `sram_r_en`=0, `sram_w_en`=0, `rdata`=0.
  - Reset mid-miss or mid-write abandons the transaction. No partial line is installed.
- Read hit: 0 wait cycles.
- Read miss: 1 + N cycles, where N = cycles until `sram_ready`. `ready` rises in the `sram_ready` cycle.
- Store: same latency as a read miss, regardless of hit.
- Back-to-back: a new request is decoded in the IDLE cycle immediately after completion. There is no dead cycle beyond the state return.
- `sram_ready` seen while in IDLE is ignored.
- Write-hit update happens exactly once, at the IDLE→WR_THRU edge.

## Test plan
- Reset, then `mem_r_en`=0 and `mem_w_en`=0 → `ready`=1, both SRAM enables 0, all sets invalid; a read of 1024 misses.
- Read 1024 with the SRAM returning 64'h2222_2222_1111_1111 after 5 cycles → `ready`=0 for 5 cycles, then `rdata`=32'h1111_1111. Next read of 1028 → `rdata`=32'h2222_2222 with `ready`=1 in the same cycle and `sram_r_en`=0.
- Fill 1024 (way0), 1536 (way1), read 1024 again, then read 2048 (same set 0) → 2048 evicts way1 (1536). Re-reading 1024 hits; re-reading 1536 misses.
- Store 32'hDEAD_BEEF to cached 1028 → `sram_w_en` held until `sram_ready`. A following read of 1028 hits with `rdata`=32'hDEAD_BEEF and no SRAM read.
- Store to uncached 4096 → write-through occurs. A following read of 4096 misses; no allocation.
- Assert `rst`=0 two cycles into a read miss → outputs return to reset values immediately. After release, the same address misses again.
